serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl.sv | 137 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder with start/result handshake: one operand bit per cycle, LSB first.
// Optional signed-overflow output OVF is built when SERIAL_ADDER_OVF_EN is defined.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             IN_READY,
    output logic             BUSY,
    output logic [WIDTH-1:0] SUM,
    output logic             CARRY,
    output logic             OUT_VALID,
    input  logic             OUT_READY
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             carry_q, carry_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Full adder built from two half-adder cells.
    logic ha1_s, ha1_c, ha2_c, bit_s, bit_cout, last_bit;
    assign ha1_s    = a_q[0] ^ b_q[0];
    assign ha1_c    = a_q[0] & b_q[0];
    assign bit_s    = ha1_s ^ c_q;
    assign ha2_c    = ha1_s & c_q;
    assign bit_cout = ha1_c | ha2_c;
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            carry_q <= carry_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        carry_d = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (START) begin
                    a_d     = A;
                    b_d     = B;
                    sum_d   = '0;
                    cnt_d   = '0;
                    c_d     = 1'b0;
                    carry_d = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                sum_d = {bit_s, sum_q[WIDTH-1:1]};
                c_d   = bit_cout;
                cnt_d = cnt_q + 1'b1;
                if (last_bit) begin
                    cnt_d   = '0;
                    carry_d = bit_cout;
`ifdef SERIAL_ADDER_OVF_EN
                    // c_q here is the carry into the MSB.
                    ovf_d   = c_q ^ bit_cout;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign IN_READY  = (state_q == IDLE);
    assign BUSY      = (state_q == SHIFT);
    assign OUT_VALID = (state_q == DONE);
    assign SUM       = sum_q;
    assign CARRY     = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign OVF       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl; checks OVF too when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         START;
    logic [W-1:0] A, B;
    logic         IN_READY, BUSY, CARRY, OUT_VALID, OUT_READY;
    logic [W-1:0] SUM;
`ifdef SERIAL_ADDER_OVF_EN
    logic         OVF;
`endif

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (START),
        .A         (A),
        .B         (B),
        .IN_READY  (IN_READY),
        .BUSY      (BUSY),
        .SUM       (SUM),
        .CARRY     (CARRY),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .OVF       (OVF)
`endif
    );

    always #5 CLK = ~CLK;

    int unsigned    n_checks = 0;
    int unsigned    n_fail   = 0;
    logic           ready_default = 1'b0;
    logic [W+1:0]   sb_q[$];   // {ovf, carry, sum}

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_result(input string tag, input logic [W+1:0] e);
        chk({tag, "_sum"}, 64'(SUM), 64'(e[W-1:0]));
        chk({tag, "_carry"}, 64'(CARRY), 64'(e[W]));
`ifdef SERIAL_ADDER_OVF_EN
        chk({tag, "_ovf"}, 64'(OVF), 64'(e[W+1]));
`endif
    endtask

    // Runs one add: optional extra START during SHIFT, hold cycles with OUT_READY low,
    // and optional START raised alongside OUT_READY in DONE.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int unsigned hold,
                         input bit poke, input bit start_in_done);
        logic [W:0]   full;
        logic         ovf;
        logic [W+1:0] e;
        int unsigned  cyc, busy_cnt, wait_cnt;
        wait_cnt = 0;
        while (!IN_READY && wait_cnt < 20) begin
            tick();
            wait_cnt++;
        end
        chk("wait_in_ready", 64'(IN_READY), 64'd1);
        full = {1'b0, a} + {1'b0, b};
        ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        sb_q.push_back({ovf, full});
        A = a; B = b; START = 1'b1;
        tick();
        START = 1'b0;
        cyc = 0; busy_cnt = 0;
        while (!OUT_VALID && cyc < 4 * W) begin
            chk("in_ready_low", 64'(IN_READY), 64'd0);
            if (BUSY) busy_cnt++;
            if (poke && cyc == 3) begin
                START = 1'b1; A = ~a; B = b + 8'd1;
            end
            tick();
            START = 1'b0;
            cyc++;
        end
        chk("out_valid", 64'(OUT_VALID), 64'd1);
        chk("latency", 64'(cyc), 64'(W));
        chk("busy_cycles", 64'(busy_cnt), 64'(W));
        if (sb_q.size() == 0) begin
            chk("sb_nonempty", 64'd0, 64'd1);
            e = '0;
        end else begin
            e = sb_q.pop_front();
        end
        check_result("result", e);
        for (int i = 0; i < int'(hold); i++) begin
            tick();
            chk("hold_valid", 64'(OUT_VALID), 64'd1);
            check_result("hold", e);
        end
        OUT_READY = 1'b1;
        START     = start_in_done;
        tick();
        chk("idle_in_ready", 64'(IN_READY), 64'd1);
        chk("idle_valid", 64'(OUT_VALID), 64'd0);
        chk("idle_busy", 64'(BUSY), 64'd0);
        START     = 1'b0;
        OUT_READY = ready_default;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"}, 64'(IN_READY), 64'd1);
        chk({tag, "_busy"}, 64'(BUSY), 64'd0);
        chk({tag, "_valid"}, 64'(OUT_VALID), 64'd0);
        chk({tag, "_sum"}, 64'(SUM), 64'd0);
        chk({tag, "_carry"}, 64'(CARRY), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk({tag, "_ovf"}, 64'(OVF), 64'd0);
`endif
    endtask

    initial begin
        RST_N = 1'b0; START = 1'b0; A = '0; B = '0; OUT_READY = 1'b0;
        tick();
        tick();
        check_reset_state("reset");
        RST_N = 1'b1;

        do_op(8'hFF, 8'h01, 0, 1'b0, 1'b0);

        ready_default = 1'b1;
        OUT_READY     = 1'b1;
        do_op(8'h00, 8'h00, 0, 1'b0, 1'b0);
        do_op(8'hA5, 8'h5A, 0, 1'b0, 1'b0);
        ready_default = 1'b0;
        OUT_READY     = 1'b0;

        do_op(8'h3C, 8'h0F, 5, 1'b0, 1'b0);
        do_op(8'h10, 8'h20, 0, 1'b1, 1'b0);
        do_op(8'h12, 8'h34, 1, 1'b0, 1'b1);

        // Reset at bit 4 of FF+FF: nothing may come out of the discarded add.
        A = 8'hFF; B = 8'hFF; START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_busy", 64'(BUSY), 64'd1);
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        check_reset_state("midreset");
        tick();
        chk("midreset_no_valid", 64'(OUT_VALID), 64'd0);
        do_op(8'hFF, 8'hFF, 0, 1'b0, 1'b0);

        do_op(8'h7F, 8'h01, 0, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 0, 1'b0, 1'b0);
        do_op(8'h80, 8'h80, 0, 1'b0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            do_op(W'($urandom), W'($urandom), $urandom_range(0, 2), 1'b0, 1'b0);
        end

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
